// File: rtl/controlador_turnos.sv
// controlador_turnos: two-player turn scheduler driving the shared 10 s turn timer.
// Optional freeze of the running turn when CONTROLADOR_PAUSA_EN is defined.
`default_nettype none

module controlador_turnos #(
    parameter int MAX_TIMEOUTS  = 3,
    parameter int CAMBIO_CICLOS = 4,
    parameter int TURNO_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inicio,
    input  logic [1:0]         jugada_valida,
    input  logic               victoria,
    input  logic               pausa,
    input  logic               tiempo_agotado,
    output logic               timer_rst,
    output logic               timer_en,
    output logic               jugador_actual,
    output logic [TURNO_W-1:0] num_turno,
    output logic               jugada_auto,
    output logic               fin_juego,
    output logic               ganador,
    output logic [1:0]         estado
);

    localparam logic [1:0] INICIO = 2'd0;
    localparam logic [1:0] TURNO  = 2'd1;
    localparam logic [1:0] CAMBIO = 2'd2;
    localparam logic [1:0] FIN    = 2'd3;

    localparam int CNT_W = (CAMBIO_CICLOS > 1) ? $clog2(CAMBIO_CICLOS) : 1;

    logic [1:0][2:0]    timeouts, timeouts_next;
    logic [CNT_W-1:0]   cambio_cnt, cambio_cnt_next;
    logic [1:0]         estado_next;
    logic               jugador_next;
    logic [TURNO_W-1:0] num_turno_next;
    logic               auto_next;
    logic               fin_next;
    logic               ganador_next;
    logic               pausado;
    logic [2:0]         to_inc;

`ifdef CONTROLADOR_PAUSA_EN
    logic pausa_efectiva;
    assign pausa_efectiva = pausa;
`else
    logic pausa_efectiva;
    logic unused_pausa;
    assign pausa_efectiva = 1'b0;
    assign unused_pausa   = pausa;
`endif

    always_comb begin
        estado_next     = estado;
        jugador_next    = jugador_actual;
        num_turno_next  = num_turno;
        auto_next       = 1'b0;
        fin_next        = fin_juego;
        ganador_next    = ganador;
        timeouts_next   = timeouts;
        cambio_cnt_next = cambio_cnt;
        pausado         = 1'b0;
        to_inc          = timeouts[jugador_actual] + 3'd1;

        // Restart has priority over everything else, in every state.
        if (inicio) begin
            estado_next     = TURNO;
            jugador_next    = 1'b0;
            num_turno_next  = '0;
            fin_next        = 1'b0;
            timeouts_next   = '0;
            cambio_cnt_next = '0;
        end else begin
            case (estado)
                TURNO: begin
                    pausado = pausa_efectiva;
                    if (!pausado) begin
                        if (jugada_valida[jugador_actual]) begin
                            if (victoria) begin
                                estado_next  = FIN;
                                fin_next     = 1'b1;
                                ganador_next = jugador_actual;
                            end else begin
                                timeouts_next[jugador_actual] = 3'd0;
                                estado_next     = CAMBIO;
                                cambio_cnt_next = '0;
                            end
                        end else if (tiempo_agotado) begin
                            auto_next = 1'b1;
                            timeouts_next[jugador_actual] = to_inc;
                            if (to_inc == 3'(MAX_TIMEOUTS)) begin
                                estado_next  = FIN;
                                fin_next     = 1'b1;
                                ganador_next = ~jugador_actual;
                            end else begin
                                estado_next     = CAMBIO;
                                cambio_cnt_next = '0;
                            end
                        end
                    end
                end
                CAMBIO: begin
                    if (cambio_cnt == CNT_W'(CAMBIO_CICLOS - 1)) begin
                        estado_next     = TURNO;
                        jugador_next    = ~jugador_actual;
                        cambio_cnt_next = '0;
                        if (num_turno != {TURNO_W{1'b1}}) begin
                            num_turno_next = num_turno + 1'b1;
                        end
                    end else begin
                        cambio_cnt_next = cambio_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Timer controls are registered from the next state so they line up with estado.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado         <= INICIO;
            timer_rst      <= 1'b1;
            timer_en       <= 1'b0;
            jugador_actual <= 1'b0;
            num_turno      <= '0;
            jugada_auto    <= 1'b0;
            fin_juego      <= 1'b0;
            ganador        <= 1'b0;
            timeouts       <= '0;
            cambio_cnt     <= '0;
        end else begin
            estado         <= estado_next;
            timer_rst      <= (estado_next != TURNO);
            timer_en       <= (estado_next == TURNO) && !pausado;
            jugador_actual <= jugador_next;
            num_turno      <= num_turno_next;
            jugada_auto    <= auto_next;
            fin_juego      <= fin_next;
            ganador        <= ganador_next;
            timeouts       <= timeouts_next;
            cambio_cnt     <= cambio_cnt_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_controlador_turnos.sv
// tb_controlador_turnos: directed plus random stimulus, scoreboard against a turn-level model.
`default_nettype none

module tb_controlador_turnos;

    localparam int MAX_TO = 3;
    localparam int CC     = 4;
    localparam int TW     = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          inicio = 1'b0;
    logic [1:0]    jugada_valida = 2'b00;
    logic          victoria = 1'b0;
    logic          pausa = 1'b0;
    logic          tiempo_agotado = 1'b0;
    logic          timer_rst, timer_en, jugador_actual, jugada_auto, fin_juego, ganador;
    logic [TW-1:0] num_turno;
    logic [1:0]    estado;

    always #5 clk = ~clk;

    controlador_turnos #(
        .MAX_TIMEOUTS (MAX_TO),
        .CAMBIO_CICLOS(CC),
        .TURNO_W      (TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .inicio        (inicio),
        .jugada_valida (jugada_valida),
        .victoria      (victoria),
        .pausa         (pausa),
        .tiempo_agotado(tiempo_agotado),
        .timer_rst     (timer_rst),
        .timer_en      (timer_en),
        .jugador_actual(jugador_actual),
        .num_turno     (num_turno),
        .jugada_auto   (jugada_auto),
        .fin_juego     (fin_juego),
        .ganador       (ganador),
        .estado        (estado)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];

    // Reference model: game phase, whose turn, turns played, per-player timeout streaks.
    int m_phase, m_player, m_turns, m_left;
    int m_to[2];
    bit m_fin, m_win, m_auto, m_paused;

    function automatic logic [15:0] pack(input int ph, input bit trst, input bit ten, input int pl,
                                         input int tn, input bit au, input bit fi, input bit gw);
        logic [15:0] v;
        v[15:14] = 2'(ph);
        v[13]    = trst;
        v[12]    = ten;
        v[11]    = pl[0];
        v[10:3]  = 8'(tn);
        v[2]     = au;
        v[1]     = fi;
        v[0]     = gw;
        return v;
    endfunction

    task automatic model_step(input bit rst_n, input bit ini, input logic [1:0] jv,
                              input bit vic, input bit pau, input bit to);
        m_auto   = 1'b0;
        m_paused = 1'b0;
        if (!rst_n) begin
            m_phase = 0; m_player = 0; m_turns = 0; m_left = 0;
            m_to[0] = 0; m_to[1] = 0; m_fin = 0; m_win = 0;
        end else if (ini) begin
            m_phase = 1; m_player = 0; m_turns = 0;
            m_to[0] = 0; m_to[1] = 0; m_fin = 0;
        end else if (m_phase == 1) begin
`ifdef CONTROLADOR_PAUSA_EN
            m_paused = pau;
`endif
            if (!m_paused) begin
                if (jv[m_player]) begin
                    if (vic) begin
                        m_phase = 3; m_fin = 1; m_win = m_player[0];
                    end else begin
                        m_to[m_player] = 0; m_phase = 2; m_left = CC;
                    end
                end else if (to) begin
                    m_auto = 1;
                    m_to[m_player] = m_to[m_player] + 1;
                    if (m_to[m_player] == MAX_TO) begin
                        m_phase = 3; m_fin = 1; m_win = !m_player[0];
                    end else begin
                        m_phase = 2; m_left = CC;
                    end
                end
            end
        end else if (m_phase == 2) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_phase  = 1;
                m_player = 1 - m_player;
                m_turns  = (m_turns < 255) ? m_turns + 1 : 255;
            end
        end
    endtask

    task automatic step(input bit rst_n, input bit ini, input logic [1:0] jv,
                        input bit vic, input bit pau, input bit to);
        @(negedge clk);
        reset          = rst_n;
        inicio         = ini;
        jugada_valida  = jv;
        victoria       = vic;
        pausa          = pau;
        tiempo_agotado = to;
        model_step(rst_n, ini, jv, vic, pau, to);
        exp_q.push_back(pack(m_phase, m_phase != 1, (m_phase == 1) && !m_paused, m_player,
                             m_turns, m_auto, m_fin, m_win));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 2'b00, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a fresh registered output set.
    initial begin
        logic [15:0] e, a, mask;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {estado, timer_rst, timer_en, jugador_actual, num_turno, jugada_auto, fin_juego, ganador};
                mask = e[1] ? 16'hFFFF : 16'hFFFE;  // ganador only meaningful at game over
                checks++;
                if ((a & mask) !== (e & mask)) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d: got estado=%0d trst=%0b ten=%0b jug=%0d turno=%0d auto=%0b fin=%0b gan=%0b, expected estado=%0d trst=%0b ten=%0b jug=%0d turno=%0d auto=%0b fin=%0b gan=%0b",
                             cyc, a[15:14], a[13], a[12], a[11], a[10:3], a[2], a[1], a[0],
                             e[15:14], e[13], e[12], e[11], e[10:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        step(0, 0, 2'b00, 0, 0, 0);
        step(0, 0, 2'b00, 0, 0, 0);
        idle(2);
        step(1, 1, 2'b00, 0, 0, 0);     // start: P0 turn
        step(1, 0, 2'b01, 0, 0, 0);     // P0 moves
        idle(CC);
        step(1, 0, 2'b00, 0, 0, 1);     // P1 timeout #1
        idle(CC);
        step(1, 0, 2'b01, 0, 0, 1);     // P0 move and timeout together
        idle(CC);
        step(1, 0, 2'b01, 1, 0, 1);     // P0 ignored (not active), P1 timeout #2
        idle(CC);
        step(1, 0, 2'b01, 0, 0, 0);
        idle(CC);
        step(1, 0, 2'b00, 0, 0, 1);     // P1 timeout #3 -> forfeit, winner P0
        idle(3);
        step(1, 1, 2'b00, 0, 0, 0);
        step(1, 0, 2'b01, 0, 0, 0);
        idle(CC);
        step(1, 0, 2'b10, 1, 0, 0);     // P1 winning move
        idle(2);
        step(1, 1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 100; i++) step(1, 0, 2'(i % 4), 0, 1, i[0]);
        idle(3);
        step(1, 0, 2'b01, 0, 0, 0);
        idle(2);
        step(0, 0, 2'b00, 0, 0, 0);     // reset mid-change
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] jv;
            logic       pz;
            jv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            pz = ($urandom_range(0, 9) < 3);
            step(($urandom_range(0, 999) != 0), ($urandom_range(0, 99) == 0), jv,
                 ($urandom_range(0, 7) == 0), pz, ($urandom_range(0, 5) == 0));
        end
        idle(2);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/controlador_turnos.md
Name: controlador_turnos

Overview:
- Two-player turn scheduler that owns the shared 10 s turn timer (`temporizador_10s`).
- Holds the timer in reset between turns and enables it during a turn.
- Consumes the timer's timeout flag, forces an automatic move on timeout and alternates the active player.
- Declares a forfeit after too many consecutive timeouts; sits between the player-input logic and the game/display FSM.

Parameters:
- MAX_TIMEOUTS, 3: consecutive timeouts by one player that end the game (range 1..7).
- CAMBIO_CICLOS, 4: cycles spent in CAMBIO holding the timer in reset (≥1).
- TURNO_W, 8: width of the turn counter.

Ports:
- clk  in  1  system clock (25 MHz)
- reset  in  1  asynchronous, active-low reset
- inicio  in  1  1-cycle start/restart pulse
- jugada_valida  in  2  bit i = player i committed a legal move (1-cycle pulse)
- victoria  in  1  qualifies jugada_valida: the move just made wins the game
- pausa  in  1  freeze request (see Optional Feature)
- tiempo_agotado  in  1  timer timeout flag
- timer_rst  out  1  active-high reset to the timer
- timer_en  out  1  enable to the timer
- jugador_actual  out  1  active player, 0 or 1
- num_turno  out  TURNO_W  completed-turn count, saturating
- jugada_auto  out  1  1-cycle pulse: game logic must place an automatic move for jugador_actual
- fin_juego  out  1  game over
- ganador  out  1  winner, valid while fin_juego=1
- estado  out  2  state code: INICIO=0, TURNO=1, CAMBIO=2, FIN=3

Behaviour:
- All outputs are registered; each reflects the state/event of the previous clock edge, giving 1-cycle latency.
- Reset (reset=0, asynchronous) values:
  - estado=INICIO, timer_rst=1, timer_en=0.
  - jugador_actual=0, num_turno=0, jugada_auto=0, fin_juego=0, ganador=0.
  - Both timeout counters = 0, CAMBIO cycle counter = 0.
- INICIO: timer_rst=1, timer_en=0. On inicio=1 → TURNO with jugador_actual=0.
- TURNO: timer_rst=0, timer_en=1. Events are evaluated in this priority order:
  1. jugada_valida[jugador_actual]=1 with victoria=1 → FIN; ganador=jugador_actual; fin_juego=1.
  2. jugada_valida[jugador_actual]=1 → clear that player's timeout counter; → CAMBIO.
  3. tiempo_agotado=1 → jugada_auto=1 for exactly one cycle; increment that player's timeout counter.
     - If the new count equals MAX_TIMEOUTS → FIN; ganador=~jugador_actual.
     - Otherwise → CAMBIO.
- In TURNO, jugada_valida from the non-active player is ignored, and victoria without jugada_valida is ignored.
- A move and a timeout in the same cycle: the move wins; no jugada_auto, no timeout count.
- CAMBIO:
  - timer_rst=1, timer_en=0 for exactly CAMBIO_CICLOS cycles.
  - On the last cycle: toggle jugador_actual; num_turno+1, saturating at all-ones; → TURNO.
  - All inputs are ignored except inicio.
- FIN: timer_rst=1, timer_en=0, fin_juego=1, ganador held. On inicio=1: clear num_turno, timeout counters and fin_juego; → TURNO with jugador_actual=0.
- inicio while in TURNO or CAMBIO restarts the game exactly as from FIN.
- Timer handshake: timer_rst is held through CAMBIO, so the timer re-enters TURNO at 10 s with tiempo_agotado=0. A stale timeout flag cannot be consumed twice.
- Reset asserted mid-turn returns to INICIO immediately; the timer is held in reset from the next output update.
- num_turno does not increment on transitions into FIN.

Optional Feature:
- Macro: CONTROLADOR_PAUSA_EN.
- Defined:
  - In TURNO with pausa=1: timer_en=0 and state is held.
  - jugada_valida and tiempo_agotado are ignored; timer_rst stays 0, so remaining seconds are preserved.
  - Releasing pausa resumes with the same player.
  - pausa has no effect in other states.
- Undefined: the pausa port exists but is ignored; TURNO behaves as above.

Test Plan:
- Reset low, then inicio pulse → estado=TURNO, jugador_actual=0, timer_rst=0, timer_en=1 one cycle later.
- P0 jugada_valida=01 → CAMBIO for 4 cycles with timer_rst=1, then jugador_actual=1 and num_turno=1.
- Force tiempo_agotado=1 in TURNO → one jugada_auto pulse, CAMBIO, player toggles. Three consecutive timeouts by P1 with P0 moving in between → FIN, fin_juego=1, ganador=0.
- jugada_valida=01 and tiempo_agotado=1 in the same cycle with P0 active → no jugada_auto, P0 timeout count stays 0, CAMBIO entered.
- P1 jugada_valida=10 with victoria=1 → FIN, ganador=1. inicio pulse → TURNO, jugador_actual=0, num_turno=0.
- With CONTROLADOR_PAUSA_EN: pausa=1 for 100 cycles in TURNO → timer_en=0 and jugada_valida ignored. After release, the same player is active and timer_en=1.
